// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the accumulator/ALU sequencer: widths, ALU function codes,
// opcode and FSM encodings, and status-register bit positions.
package alu_sequencer_pkg;

   localparam int REG_WIDTH = 8;
   localparam int OPP_WIDTH = 5;

   localparam logic [OPP_WIDTH-1:0] FUNC_NONE = 5'b00000;
   localparam logic [OPP_WIDTH-1:0] FUNC_SUM  = 5'b00001;
   localparam logic [OPP_WIDTH-1:0] FUNC_AND  = 5'b00010;
   localparam logic [OPP_WIDTH-1:0] FUNC_OR   = 5'b00100;
   localparam logic [OPP_WIDTH-1:0] FUNC_XOR  = 5'b01000;
   localparam logic [OPP_WIDTH-1:0] FUNC_SR   = 5'b10000;

   localparam int FLAG_CARRY    = 0;
   localparam int FLAG_ZERO     = 1;
   localparam int FLAG_IRQ      = 2;
   localparam int FLAG_DEC      = 3;
   localparam int FLAG_BRK      = 4;
   localparam int FLAG_ONE      = 5;
   localparam int FLAG_OVERFLOW = 6;
   localparam int FLAG_NEG      = 7;

   localparam logic [REG_WIDTH-1:0] P_RESET = 8'h20;

   typedef enum logic [2:0] {
      OP_ADC = 3'd0,
      OP_SBC = 3'd1,
      OP_AND = 3'd2,
      OP_ORA = 3'd3,
      OP_EOR = 3'd4,
      OP_ASL = 3'd5,
      OP_CMP = 3'd6,
      OP_LDA = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

   function automatic logic [OPP_WIDTH-1:0] opFunc(input op_e op);
      logic [OPP_WIDTH-1:0] f;
      case (op)
         OP_ADC, OP_SBC, OP_CMP: f = FUNC_SUM;
         OP_AND:                 f = FUNC_AND;
         OP_ORA:                 f = FUNC_OR;
         OP_EOR:                 f = FUNC_XOR;
         OP_ASL:                 f = FUNC_SR;
         default:                f = FUNC_NONE;
      endcase
      return f;
   endfunction

   // Which P bits an opcode is allowed to overwrite at writeback.
   function automatic logic [REG_WIDTH-1:0] flagMask(input op_e op);
      logic [REG_WIDTH-1:0] m;
      m = '0;
      m[FLAG_ZERO] = 1'b1;
      m[FLAG_NEG]  = 1'b1;
      case (op)
         OP_ADC, OP_SBC: begin
            m[FLAG_CARRY]    = 1'b1;
            m[FLAG_OVERFLOW] = 1'b1;
         end
         OP_ASL, OP_CMP: m[FLAG_CARRY] = 1'b1;
         default: ;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Accumulator sequencer: accepts one opcode at a time, drives an external ALU,
// waits (bounded) for its result and writes back the accumulator and P flags.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic                 phi1,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_op,
   input  logic [REG_WIDTH-1:0] req_operand,
   output logic [OPP_WIDTH-1:0] alu_func,
   output logic [REG_WIDTH-1:0] alu_a,
   output logic [REG_WIDTH-1:0] alu_b,
   output logic [REG_WIDTH-1:0] alu_status_in,
   input  logic [REG_WIDTH-1:0] alu_dout,
   input  logic [REG_WIDTH-1:0] alu_status_out,
   input  logic                 alu_wout,
   output logic [REG_WIDTH-1:0] acc_out,
   output logic [REG_WIDTH-1:0] p_out,
   output logic                 done,
   output logic                 err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [REG_WIDTH-1:0] operand_q, operand_d;
   logic [REG_WIDTH-1:0] acc_q, acc_d;
   logic [REG_WIDTH-1:0] p_q, p_d;
   logic [REG_WIDTH-1:0] res_q, res_d;
   logic [REG_WIDTH-1:0] resFlags_q, resFlags_d;
   logic [CNT_W-1:0]     waitCnt_q, waitCnt_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 ready_q;
   logic                 aluActive;
   logic [REG_WIDTH-1:0] ldaFlags, mask, newFlags;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      operand_d  = operand_q;
      acc_d      = acc_q;
      p_d        = p_q;
      res_d      = res_q;
      resFlags_d = resFlags_q;
      waitCnt_d  = waitCnt_q;
      done_d     = 1'b0;
      err_d      = err_q;

      // ready_q keeps req_ready low through reset and until the first edge after it.
      req_ready     = ready_q && (state_q == ST_IDLE);
      aluActive     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
      alu_func      = '0;
      alu_a         = '0;
      alu_b         = '0;
      alu_status_in = '0;

      ldaFlags            = '0;
      ldaFlags[FLAG_ZERO] = (operand_q == '0);
      ldaFlags[FLAG_NEG]  = operand_q[REG_WIDTH-1];
      mask                = flagMask(op_q);
      newFlags            = (op_q == OP_LDA) ? ldaFlags : resFlags_q;

      // Subtraction is a + ~b + C; CMP forces the carry so it is a pure a - b.
      if (aluActive) begin
         alu_func      = opFunc(op_q);
         alu_a         = acc_q;
         alu_b         = operand_q;
         alu_status_in = p_q;
         case (op_q)
            OP_SBC: alu_b = ~operand_q;
            OP_CMP: begin
               alu_b                     = ~operand_q;
               alu_status_in[FLAG_CARRY] = 1'b1;
            end
            OP_ASL: alu_b = REG_WIDTH'(1);
            default: ;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               op_d      = op_e'(req_op);
               operand_d = req_operand;
               state_d   = (op_e'(req_op) == OP_LDA) ? ST_WRITE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            waitCnt_d = '0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            // The ALU need not hold its result, so capture it the cycle it is flagged.
            if (alu_wout) begin
               res_d      = alu_dout;
               resFlags_d = alu_status_out;
               state_d    = ST_WRITE;
            end else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
         end
         ST_WRITE: begin
            if (op_q == OP_LDA) begin
               acc_d = operand_q;
            end else if (op_q != OP_CMP) begin
               acc_d = res_q;
            end
            p_d           = (p_q & ~mask) | (newFlags & mask);
            p_d[FLAG_ONE] = 1'b1;
            done_d        = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge phi1 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_ADC;
         operand_q  <= '0;
         acc_q      <= '0;
         p_q        <= P_RESET;
         res_q      <= '0;
         resFlags_q <= '0;
         waitCnt_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         operand_q  <= operand_d;
         acc_q      <= acc_d;
         p_q        <= p_d;
         res_q      <= res_d;
         resFlags_q <= resFlags_d;
         waitCnt_q  <= waitCnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ready_q    <= 1'b1;
      end
   end

   assign acc_out = acc_q;
   assign p_out   = p_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU responds to the DUT,
// a reference model predicts acc/P and a scoreboard queue holds the expectations.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int TIMEOUT = 8;

   logic       phi1        = 1'b0;
   logic       reset_n     = 1'b0;
   logic       req_valid   = 1'b0;
   logic [2:0] req_op      = 3'd0;
   logic [7:0] req_operand = 8'h00;
   logic       req_ready;
   logic [4:0] alu_func;
   logic [7:0] alu_a, alu_b, alu_status_in;
   logic [7:0] alu_dout, alu_status_out;
   logic       alu_wout    = 1'b0;
   logic [7:0] acc_out, p_out;
   logic       done, err;

   alu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .phi1(phi1), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_operand(req_operand),
      .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_status_in(alu_status_in),
      .alu_dout(alu_dout), .alu_status_out(alu_status_out), .alu_wout(alu_wout),
      .acc_out(acc_out), .p_out(p_out), .done(done), .err(err)
   );

   always #5 phi1 = ~phi1;

   typedef struct {
      string      tag;
      logic [7:0] acc;
      logic [7:0] p;
      int         lat;
   } exp_t;

   exp_t sb[$];

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int doneCount  = 0;
   int acceptCount = 0;
   int funcCycles = 0;
   int funcBad    = 0;
   int aluCyc     = 0;
   logic withhold = 1'b0;
   logic [7:0] modelAcc = 8'h00;
   logic [7:0] modelP   = 8'h20;

   // Behavioural ALU: combinational result, valid flagged in the second busy cycle.
   always_comb begin
      logic [8:0] sum9;
      sum9           = '0;
      alu_dout       = '0;
      alu_status_out = alu_status_in;
      case (alu_func)
         FUNC_SUM: begin
            sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_status_in[0]};
            alu_dout = sum9[7:0];
            alu_status_out[0] = sum9[8];
            alu_status_out[6] = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
         end
         FUNC_AND: alu_dout = alu_a & alu_b;
         FUNC_OR:  alu_dout = alu_a | alu_b;
         FUNC_XOR: alu_dout = alu_a ^ alu_b;
         FUNC_SR: begin
            alu_dout = alu_a << alu_b[2:0];
            alu_status_out[0] = alu_a[7];
         end
         default: ;
      endcase
      alu_status_out[1] = (alu_dout == 8'h00);
      alu_status_out[7] = alu_dout[7];
   end

   always @(negedge phi1) begin
      if (alu_func != '0) aluCyc = aluCyc + 1;
      else aluCyc = 0;
      alu_wout = (aluCyc == 2) && !withhold;
   end

   // Event counters sampled on the active edge, before the DUT registers update.
   always @(posedge phi1) begin
      if (done) doneCount++;
      if (req_valid && req_ready) acceptCount++;
      if (alu_func != '0) begin
         funcCycles++;
         if (!$onehot(alu_func)) funcBad++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge phi1);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 6502-style reference for the accumulator and the C/Z/V/N flags.
   task automatic refExec(input logic [2:0] op, input logic [7:0] v);
      logic [8:0] s;
      logic [7:0] r;
      s = '0;
      r = modelAcc;
      case (op)
         3'd0: begin
            s = {1'b0, modelAcc} + {1'b0, v} + {8'b0, modelP[0]};
            modelP[6] = (modelAcc[7] == v[7]) && (s[7] != modelAcc[7]);
            modelP[0] = s[8];
            r = s[7:0];
            modelAcc = r;
         end
         3'd1: begin
            s = {1'b0, modelAcc} + {1'b0, ~v} + {8'b0, modelP[0]};
            modelP[6] = (modelAcc[7] != v[7]) && (s[7] != modelAcc[7]);
            modelP[0] = s[8];
            r = s[7:0];
            modelAcc = r;
         end
         3'd2: begin r = modelAcc & v; modelAcc = r; end
         3'd3: begin r = modelAcc | v; modelAcc = r; end
         3'd4: begin r = modelAcc ^ v; modelAcc = r; end
         3'd5: begin
            modelP[0] = modelAcc[7];
            r = {modelAcc[6:0], 1'b0};
            modelAcc = r;
         end
         3'd6: begin
            modelP[0] = (modelAcc >= v);
            r = modelAcc - v;
         end
         default: begin r = v; modelAcc = v; end
      endcase
      modelP[1] = (r == 8'h00);
      modelP[7] = r[7];
   endtask

   task automatic driveRequest(input logic [2:0] op, input logic [7:0] v);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      req_valid   = 1'b1;
      req_op      = op;
      req_operand = v;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [7:0] v);
      exp_t e;
      refExec(op, v);
      e.tag = tag;
      e.acc = modelAcc;
      e.p   = modelP;
      e.lat = (op == 3'd7) ? 1 : 3;
      sb.push_back(e);
      driveRequest(op, v);
   endtask

   task automatic checkOutput();
      exp_t e;
      int lat;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      lat = 0;
      while (!done && lat < 40) begin tick(); lat++; end
      check({e.tag, "_done"}, {31'd0, done}, 32'd1);
      check({e.tag, "_latency"}, lat, e.lat);
      check({e.tag, "_acc"}, {24'd0, acc_out}, {24'd0, e.acc});
      check({e.tag, "_p"}, {24'd0, p_out}, {24'd0, e.p});
      tick();
      check({e.tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int n;
      int base;
      int doneBase;
      int funcBase;

      // Reset state while reset_n is held low.
      #12;
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_acc", {24'd0, acc_out}, 32'h00);
      check("rst_p", {24'd0, p_out}, 32'h20);
      check("rst_func", {27'd0, alu_func}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      tick();
      reset_n = 1'b1;
      #1;
      check("ready_before_edge", {31'd0, req_ready}, 32'd0);
      tick();
      check("ready_after_edge", {31'd0, req_ready}, 32'd1);

      $display("[TB] directed arithmetic and logic sequence");
      applyStimulus("lda50", 3'd7, 8'h50); checkOutput();
      applyStimulus("adc50", 3'd0, 8'h50); checkOutput();
      applyStimulus("ldaFF", 3'd7, 8'hFF); checkOutput();
      applyStimulus("adc01", 3'd0, 8'h01); checkOutput();
      applyStimulus("lda10", 3'd7, 8'h10); checkOutput();
      applyStimulus("cmp10", 3'd6, 8'h10); checkOutput();
      applyStimulus("cmp20", 3'd6, 8'h20); checkOutput();
      applyStimulus("sbc05", 3'd1, 8'h05); checkOutput();
      applyStimulus("asl",   3'd5, 8'h00); checkOutput();
      applyStimulus("and0C", 3'd2, 8'h0C); checkOutput();
      applyStimulus("oraF0", 3'd3, 8'hF0); checkOutput();
      applyStimulus("eorFF", 3'd4, 8'hFF); checkOutput();
      applyStimulus("lda80", 3'd7, 8'h80); checkOutput();
      applyStimulus("asl80", 3'd5, 8'h00); checkOutput();

      $display("[TB] ALU timeout");
      withhold = 1'b1;
      doneBase = doneCount;
      driveRequest(3'd0, 8'h33);
      n = 0;
      while (!err && n < 40) begin tick(); n++; end
      check("to_err", {31'd0, err}, 32'd1);
      check("to_latency", n, TIMEOUT + 1);
      check("to_ready", {31'd0, req_ready}, 32'd1);
      check("to_acc", {24'd0, acc_out}, {24'd0, modelAcc});
      check("to_p", {24'd0, p_out}, {24'd0, modelP});
      tick(); tick();
      check("to_no_done", doneCount, doneBase);
      check("to_err_sticky", {31'd0, err}, 32'd1);
      withhold = 1'b0;

      $display("[TB] reset during WAIT");
      withhold = 1'b1;
      driveRequest(3'd0, 8'h05);
      tick(); tick();
      check("mid_in_wait", {27'd0, alu_func}, {27'd0, FUNC_SUM});
      reset_n = 1'b0;
      #1;
      check("mid_acc", {24'd0, acc_out}, 32'h00);
      check("mid_p", {24'd0, p_out}, 32'h20);
      check("mid_func", {27'd0, alu_func}, 32'd0);
      check("mid_ready", {31'd0, req_ready}, 32'd0);
      check("mid_err", {31'd0, err}, 32'd0);
      withhold = 1'b0;
      modelAcc = 8'h00;
      modelP   = 8'h20;
      tick();
      reset_n = 1'b1;
      doneBase = doneCount;
      repeat (6) tick();
      check("mid_no_done", doneCount, doneBase);
      check("mid_acc_after", {24'd0, acc_out}, 32'h00);
      check("mid_ready_after", {31'd0, req_ready}, 32'd1);

      $display("[TB] req_valid held for four ADC requests");
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         refExec(3'd0, 8'h11);
         e.tag = $sformatf("burst%0d", i);
         e.acc = modelAcc;
         e.p   = modelP;
         e.lat = 3;
         sb.push_back(e);
      end
      base     = acceptCount;
      doneBase = doneCount;
      funcBase = funcCycles;
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      req_valid   = 1'b1;
      req_op      = 3'd0;
      req_operand = 8'h11;
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput();
         if (i == 2) req_valid = 1'b0;
      end
      repeat (3) tick();
      check("burst_accepts", acceptCount - base, 4);
      check("burst_dones", doneCount - doneBase, 4);
      check("burst_func_cycles", funcCycles - funcBase, 8);
      check("func_onehot", funcBad, 0);
      check("burst_idle_func", {27'd0, alu_func}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 8, max cycles in WAIT for alu_wout before abort.
REQ-002 phi1  in  1  sole clock, rising-edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  operation request.
REQ-005 req_ready  out  1  high only in IDLE.
REQ-006 req_op  in  3  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 CMP, 7 LDA.
REQ-007 req_operand  in  REG_WIDTH  memory/immediate operand.
REQ-008 alu_func  out  OPP_WIDTH  one-hot ALU function (SUM, AND, OR, XOR, SR).
REQ-009 alu_a, alu_b, alu_status_in  out  REG_WIDTH each  ALU operands and flags in.
REQ-010 alu_dout, alu_status_out  in  REG_WIDTH each  ALU result and flags out.
REQ-011 alu_wout  in  1  ALU result valid.
REQ-012 acc_out, p_out  out  REG_WIDTH each  accumulator and status register (P).
REQ-013 done  out  1  one-cycle pulse on writeback; err  out  1  sticky timeout flag.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, WRITE; request accepted on req_valid && req_ready, latching op and operand.
REQ-015 IDLE->ISSUE on accept (LDA: IDLE->WRITE, no ALU use); ISSUE->WAIT always; WAIT->WRITE on alu_wout; WRITE->IDLE always.
REQ-016 alu_func nonzero only in ISSUE and WAIT; zero in IDLE/WRITE.
REQ-017 Mapping: ADC/SBC/CMP->SUM, AND->AND, ORA->OR, EOR->XOR, ASL->SR with alu_b=1.
REQ-018 alu_a=acc; alu_b=operand, inverted for SBC/CMP; alu_status_in=P, with CARRY forced 1 for CMP.
REQ-019 WAIT counter starts at 0 on entry; reaching TIMEOUT without alu_wout sets err, returns IDLE, no writeback, no done.
REQ-020 WRITE: acc<=alu_dout except CMP (unchanged), LDA (acc<=operand).
REQ-021 Flags: ADC/SBC update C,Z,V,N from alu_status_out; ASL/CMP update C,Z,N; AND/ORA/EOR update Z,N; LDA computes Z,N from operand locally.
REQ-022 I, D, B bits of P never change in this block; P bit 5 reads 1 always.
REQ-023 Minimum latency accept->done: 3 cycles (ALU ops, alu_wout in first WAIT cycle); 1 cycle for LDA.
REQ-024 req_valid while busy is ignored; back-to-back accept possible on cycle after done.
REQ-025 alu_wout outside WAIT is ignored.

Reset
REQ-026 reset_n low forces immediately: state IDLE, acc 0x00, P 0x20, alu_func 0, alu_a/b/status_in 0, done 0, err 0, req_ready 0.
REQ-027 req_ready rises on first phi1 edge after reset_n deasserts.
REQ-028 Reset mid-operation discards the operation; no writeback after release.

Structure
REQ-029 Opcode encoding, FSM state encoding and flag bit indices (CARRY, ZERO, IRQ, DEC, BRK, OVERFLOW, NEG) belong in the shared package with existing REG_WIDTH, OPP_WIDTH and function codes.
REQ-030 Single module; no sub-module; ALU instantiated by the enclosing level, not inside this block.

Verification
REQ-031 LDA 0x50, ADC 0x50 (C=0) -> acc 0xA0, N=1, V=1, C=0, Z=0; done exactly one cycle, 3 cycles after accept.
REQ-032 LDA 0xFF, ADC 0x01 (C=0) -> acc 0x00, Z=1, C=1, N=0.
REQ-033 LDA 0x10, CMP 0x10 -> acc 0x10, Z=1, C=1; CMP 0x20 -> acc 0x10, C=0, N=1, Z=0.
REQ-034 ALU model withholds alu_wout for TIMEOUT cycles -> err=1, acc/P unchanged, no done, req_ready high next cycle.
REQ-035 reset_n pulsed low during WAIT -> acc 0x00, P 0x20, alu_func 0 same cycle, no done after release.
REQ-036 req_valid held high for 4 ADC requests -> each accepted only in IDLE, alu_func one-hot throughout ISSUE/WAIT, 4 done pulses.
